// File: rtl/wb_regfile.sv
// Write-back stage: MEM/WB pipeline latch feeding a 32-entry GPR array.
// Two combinational read ports see the pending latched write through a bypass.
module wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wb_wdata_i,
    input  logic [ADDR_W-1:0] wb_waddr_i,
    input  logic              wb_we_i,
    input  logic              wb_stall_i,
    input  logic              wb_flush_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic [ADDR_W-1:0] wb_waddr_o,
    output logic              wb_we_o
);

    typedef struct packed {
        logic [DATA_W-1:0] wdata;
        logic [ADDR_W-1:0] waddr;
        logic              we;
    } wb_latch_t;

    wb_latch_t         latch_q;
    logic [DATA_W-1:0] regs [NREG];

    // MEM/WB latch: flush beats stall
    always_ff @(posedge clk) begin
        if (rst) begin
            latch_q <= '0;
        end else if (wb_flush_i) begin
            latch_q <= '0;
        end else if (!wb_stall_i) begin
            latch_q.wdata <= wb_wdata_i;
            latch_q.waddr <= wb_waddr_i;
            latch_q.we    <= wb_we_i;
        end
    end

    // Commit uses the latch contents from before this edge; r0 never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[ADDR_W'(i)] <= '0;
            end
        end else if (latch_q.we && (latch_q.waddr != '0)) begin
            regs[latch_q.waddr] <= latch_q.wdata;
        end
    end

    always_comb begin
        rdata1_o = '0;
        if (!rst && re1_i && (raddr1_i != '0)) begin
            if (latch_q.we && (latch_q.waddr == raddr1_i)) begin
                rdata1_o = latch_q.wdata;
            end else begin
                rdata1_o = regs[raddr1_i];
            end
        end
    end

    always_comb begin
        rdata2_o = '0;
        if (!rst && re2_i && (raddr2_i != '0)) begin
            if (latch_q.we && (latch_q.waddr == raddr2_i)) begin
                rdata2_o = latch_q.wdata;
            end else begin
                rdata2_o = regs[raddr2_i];
            end
        end
    end

    assign wb_wdata_o = latch_q.wdata;
    assign wb_waddr_o = latch_q.waddr;
    assign wb_we_o    = latch_q.we;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table followed by a model-driven random run,
// both checked through an expected-response queue sampled on the falling edge.
module tb_wb_regfile;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREG   = 32;
    localparam int unsigned NVEC   = 27;
    localparam int unsigned NRAND  = 400;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] wb_wdata_i;
    logic [ADDR_W-1:0] wb_waddr_i;
    logic              wb_we_i;
    logic              wb_stall_i;
    logic              wb_flush_i;
    logic              re1_i;
    logic [ADDR_W-1:0] raddr1_i;
    logic [DATA_W-1:0] rdata1_o;
    logic              re2_i;
    logic [ADDR_W-1:0] raddr2_i;
    logic [DATA_W-1:0] rdata2_o;
    logic [DATA_W-1:0] wb_wdata_o;
    logic [ADDR_W-1:0] wb_waddr_o;
    logic              wb_we_o;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_wdata_i (wb_wdata_i),
        .wb_waddr_i (wb_waddr_i),
        .wb_we_i    (wb_we_i),
        .wb_stall_i (wb_stall_i),
        .wb_flush_i (wb_flush_i),
        .re1_i      (re1_i),
        .raddr1_i   (raddr1_i),
        .rdata1_o   (rdata1_o),
        .re2_i      (re2_i),
        .raddr2_i   (raddr2_i),
        .rdata2_o   (rdata2_o),
        .wb_wdata_o (wb_wdata_o),
        .wb_waddr_o (wb_waddr_o),
        .wb_we_o    (wb_we_o)
    );

    typedef struct packed {
        logic        rst;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        stall;
        logic        flush;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
    } stim_t;

    typedef struct packed {
        logic [31:0] r1;
        logic [31:0] r2;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } resp_t;

    typedef struct packed {
        stim_t s;
        resp_t e;
    } vec_t;

    vec_t  vecs [NVEC];
    resp_t sb_q [$];
    int    n_vec = 0;
    int    n_err = 0;

    // Reference model state
    logic [31:0] m_regs [NREG];
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    function automatic vec_t mkv(input logic r, input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic st, input logic fl,
                                 input logic e1, input logic [4:0] a1,
                                 input logic e2, input logic [4:0] a2,
                                 input logic [31:0] x1, input logic [31:0] x2,
                                 input logic owe, input logic [4:0] owa,
                                 input logic [31:0] owd);
        vec_t v;
        v.s = '{rst: r, we: we, waddr: wa, wdata: wd, stall: st, flush: fl,
                re1: e1, ra1: a1, re2: e2, ra2: a2};
        v.e = '{r1: x1, r2: x2, we: owe, waddr: owa, wdata: owd};
        return v;
    endfunction

    task automatic drive(input stim_t s);
        rst        = s.rst;
        wb_we_i    = s.we;
        wb_waddr_i = s.waddr;
        wb_wdata_i = s.wdata;
        wb_stall_i = s.stall;
        wb_flush_i = s.flush;
        re1_i      = s.re1;
        raddr1_i   = s.ra1;
        re2_i      = s.re2;
        raddr2_i   = s.ra2;
    endtask

    task automatic check(input string tag);
        resp_t e;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb_q.pop_front();
        if (rdata1_o !== e.r1) begin
            n_err++;
            $display("FAIL %s rdata1: got %h want %h", tag, rdata1_o, e.r1);
        end
        if (rdata2_o !== e.r2) begin
            n_err++;
            $display("FAIL %s rdata2: got %h want %h", tag, rdata2_o, e.r2);
        end
        if (wb_we_o !== e.we) begin
            n_err++;
            $display("FAIL %s wb_we_o: got %b want %b", tag, wb_we_o, e.we);
        end
        if (wb_waddr_o !== e.waddr) begin
            n_err++;
            $display("FAIL %s wb_waddr_o: got %0d want %0d", tag, wb_waddr_o, e.waddr);
        end
        if (wb_wdata_o !== e.wdata) begin
            n_err++;
            $display("FAIL %s wb_wdata_o: got %h want %h", tag, wb_wdata_o, e.wdata);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic r, input logic en, input logic [4:0] a);
        if (r || !en || a == 5'd0) return 32'd0;
        if (m_we && m_waddr == a)  return m_wdata;
        return m_regs[a];
    endfunction

    function automatic resp_t model_resp(input stim_t s);
        resp_t e;
        e.r1    = model_rd(s.rst, s.re1, s.ra1);
        e.r2    = model_rd(s.rst, s.re2, s.ra2);
        e.we    = m_we;
        e.waddr = m_waddr;
        e.wdata = m_wdata;
        return e;
    endfunction

    // Advance the model across one rising edge: commit old latch, then update latch
    task automatic model_step(input stim_t s);
        if (s.rst) begin
            for (int i = 0; i < int'(NREG); i++) m_regs[i] = 32'd0;
            m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
        end else begin
            if (m_we && m_waddr != 5'd0) m_regs[m_waddr] = m_wdata;
            if (s.flush) begin
                m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
            end else if (!s.stall) begin
                m_we = s.we; m_waddr = s.waddr; m_wdata = s.wdata;
            end
        end
    endtask

    initial begin
        stim_t s;
        // rst we wa wdata st fl re1 a1 re2 a2 | r1 r2 owe owa owdata
        vecs[0]  = mkv(1, 0, 0, 0,            0, 0, 1, 5,  1, 0,  0, 0, 0, 0, 0);
        vecs[1]  = mkv(0, 1, 5, 32'hDEADBEEF, 0, 0, 1, 5,  0, 0,  0, 0, 0, 0, 0);
        vecs[2]  = mkv(0, 0, 0, 0,            0, 0, 1, 5,  1, 5,  32'hDEADBEEF, 32'hDEADBEEF, 1, 5, 32'hDEADBEEF);
        vecs[3]  = mkv(0, 0, 0, 0,            0, 0, 1, 5,  1, 5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
        vecs[4]  = mkv(0, 1, 0, 32'hFFFFFFFF, 0, 0, 1, 0,  1, 5,  0, 32'hDEADBEEF, 0, 0, 0);
        vecs[5]  = mkv(0, 0, 0, 0,            0, 0, 1, 0,  1, 0,  0, 0, 1, 0, 32'hFFFFFFFF);
        vecs[6]  = mkv(0, 0, 0, 0,            0, 0, 1, 0,  1, 5,  0, 32'hDEADBEEF, 0, 0, 0);
        vecs[7]  = mkv(0, 1, 3, 1,            0, 0, 1, 3,  0, 0,  0, 0, 0, 0, 0);
        vecs[8]  = mkv(0, 1, 3, 2,            0, 0, 1, 3,  0, 0,  1, 0, 1, 3, 1);
        vecs[9]  = mkv(0, 0, 0, 0,            0, 0, 1, 3,  1, 3,  2, 2, 1, 3, 2);
        vecs[10] = mkv(0, 0, 0, 0,            0, 0, 1, 3,  1, 3,  2, 2, 0, 0, 0);
        vecs[11] = mkv(0, 1, 7, 32'hA5,       0, 0, 1, 7,  0, 0,  0, 0, 0, 0, 0);
        vecs[12] = mkv(0, 1, 7, 32'h55,       1, 0, 1, 7,  1, 3,  32'hA5, 2, 1, 7, 32'hA5);
        vecs[13] = mkv(0, 1, 8, 32'h66,       1, 0, 1, 7,  1, 8,  32'hA5, 0, 1, 7, 32'hA5);
        vecs[14] = mkv(0, 1, 7, 32'h77,       1, 0, 1, 7,  0, 0,  32'hA5, 0, 1, 7, 32'hA5);
        vecs[15] = mkv(0, 1, 7, 32'h99,       1, 1, 1, 7,  0, 0,  32'hA5, 0, 1, 7, 32'hA5);
        vecs[16] = mkv(0, 0, 0, 0,            0, 0, 1, 7,  1, 7,  32'hA5, 32'hA5, 0, 0, 0);
        vecs[17] = mkv(0, 1, 9, 32'h1234,     0, 0, 1, 9,  0, 0,  0, 0, 0, 0, 0);
        vecs[18] = mkv(1, 0, 0, 0,            0, 0, 1, 9,  1, 7,  0, 0, 1, 9, 32'h1234);
        vecs[19] = mkv(0, 0, 0, 0,            0, 0, 1, 9,  1, 7,  0, 0, 0, 0, 0);
        vecs[20] = mkv(0, 1, 4, 32'hCAFEF00D, 0, 0, 0, 4,  0, 4,  0, 0, 0, 0, 0);
        vecs[21] = mkv(0, 0, 0, 0,            0, 0, 0, 4,  1, 4,  0, 32'hCAFEF00D, 1, 4, 32'hCAFEF00D);
        vecs[22] = mkv(0, 0, 0, 0,            0, 0, 1, 4,  0, 4,  32'hCAFEF00D, 0, 0, 0, 0);
        vecs[23] = mkv(0, 0, 0, 0,            0, 0, 1, 4,  1, 4,  32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 0);
        vecs[24] = mkv(0, 1, 10, 32'hAAAA,    0, 0, 1, 10, 0, 0,  0, 0, 0, 0, 0);
        vecs[25] = mkv(0, 0, 0, 0,            0, 1, 1, 10, 0, 0,  32'hAAAA, 0, 1, 10, 32'hAAAA);
        vecs[26] = mkv(0, 0, 0, 0,            0, 0, 1, 10, 0, 0,  32'hAAAA, 0, 0, 0, 0);

        drive('{rst: 1'b1, default: '0});
        repeat (2) @(posedge clk);

        for (int i = 0; i < int'(NVEC); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].s);
            sb_q.push_back(vecs[i].e);
            @(negedge clk);
            check($sformatf("vec%0d", i));
        end

        // Model-checked random run; DUT latch is empty after the last vector
        for (int i = 0; i < int'(NREG); i++) m_regs[i] = 32'd0;
        m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
        for (int i = 0; i < int'(NRAND); i++) begin
            s.rst   = (i == 0) || ($urandom_range(31) == 0);
            s.we    = 1'($urandom_range(1));
            s.waddr = 5'($urandom_range(7));
            s.wdata = $urandom;
            s.stall = ($urandom_range(5) == 0);
            s.flush = ($urandom_range(7) == 0);
            s.re1   = ($urandom_range(7) != 0);
            s.ra1   = 5'($urandom_range(7));
            s.re2   = ($urandom_range(7) != 0);
            s.ra2   = 5'($urandom_range(7));
            @(posedge clk);
            #1;
            drive(s);
            sb_q.push_back(model_resp(s));
            @(negedge clk);
            check($sformatf("rnd%0d", i));
            model_step(s);
        end

        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
